// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: ALU selector codes, ALUOp encodings, R-type funct codes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_pkg;

  // ALU selector codes driven into the ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // ALUOp encodings produced by the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_control.sv
// ALU control decoder: (alu_op, funct) -> 4-bit ALU selector.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] selector
);

  // Decode ALUOp first; R-type defers to funct, unknown funct maps to the no-op code
  always_comb begin
    selector = ALU_NOP;
    unique case (alu_op)
      ALUOP_ADD: selector = ALU_ADD;
      ALUOP_SUB: selector = ALU_SUB;
      ALUOP_OR:  selector = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: selector = ALU_ADD;
          FUNCT_SUB: selector = ALU_SUB;
          FUNCT_AND: selector = ALU_AND;
          FUNCT_OR:  selector = ALU_OR;
          FUNCT_SLT: selector = ALU_SLT;
          FUNCT_NOR: selector = ALU_NOR;
          default:   selector = ALU_NOP;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-selector decode, EX/MEM + MEM/WB operand forwarding and load-use detection.
// Latency: 1 cycle from ID capture to outputs; forwarding and load_use_stall are combinational.
// Backpressure: stall holds every register; load_use_stall inserts a bubble and asks upstream to hold PC and IF/ID.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] operador1,
  output logic [DATA_W-1:0] operador2,
  output logic [3:0]        selector,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_valid,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              load_use_stall
);

  logic [3:0]        id_selector;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_alu_src;
  logic              load_bubble;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  alu_control u_alu_control (
    .alu_op   (id_alu_op),
    .funct    (id_funct),
    .selector (id_selector)
  );

  // A load in EX whose destination is read by the ID instruction cannot be forwarded in time
  assign load_use_stall = ex_valid & ex_mem_read & (ex_dest != '0) & id_valid &
                          ((ex_dest == id_rs) | ((ex_dest == id_rt) & ~id_alu_src));

  // Reset and flush clear unconditionally (flush beats stall); a load-use bubble only when not stalled
  assign load_bubble = rst | flush | (load_use_stall & ~stall);

  // Pipeline register: bubble clears everything, stall holds, otherwise capture ID
  always_ff @(posedge clk) begin
    if (load_bubble) begin
      ex_valid      <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      selector      <= 4'b0000;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_dest       <= '0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_mem_read   <= id_mem_read   & id_valid;
      ex_mem_write  <= id_mem_write  & id_valid;
      ex_reg_write  <= id_reg_write  & id_valid;
      ex_mem_to_reg <= id_mem_to_reg & id_valid;
      ex_alu_src    <= id_alu_src;
      selector      <= id_selector;
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm        <= id_imm;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_dest       <= id_reg_dst ? id_rd : id_rt;
    end
  end

  // Operand A forwarding: newest producer (EX/MEM) wins; $0 is never forwarded
  always_comb begin
    fwd_a = ex_rs_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs))
      fwd_a = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs))
      fwd_a = memwb_result;
  end

  // Operand B forwarding, same priority as A
  always_comb begin
    fwd_b = ex_rt_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rt))
      fwd_b = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rt))
      fwd_b = memwb_result;
  end

  assign operador1     = fwd_a;
  assign operador2     = ex_alu_src ? ex_imm : fwd_b;
  assign ex_store_data = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
// Latency: inputs driven 1ns after the rising edge, outputs checked 1ns after the next edge.
// Backpressure: exercises stall, flush and load-use bubbles.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [1:0]        id_alu_op;
  logic [5:0]        id_funct;
  logic              id_alu_src;
  logic              id_reg_dst;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_reg_write;
  logic              id_mem_to_reg;
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic [DATA_W-1:0] operador1;
  logic [DATA_W-1:0] operador2;
  logic [3:0]        selector;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_valid;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic              load_use_stall;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .operador1(operador1), .operador2(operador2), .selector(selector),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alu_op = 2'b00; id_funct = 6'b0;
    id_alu_src = 0; id_reg_dst = 0; id_mem_read = 0; id_mem_write = 0;
    id_reg_write = 0; id_mem_to_reg = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_checks++; if (operador1 !== 32'h0) $display("FAIL reset_op1 got %h exp 0", operador1); else n_pass++;
    n_checks++; if (operador2 !== 32'h0) $display("FAIL reset_op2 got %h exp 0", operador2); else n_pass++;
    n_checks++; if (selector !== 4'b0000) $display("FAIL reset_sel got %b exp 0000", selector); else n_pass++;
    n_checks++; if (ex_store_data !== 32'h0) $display("FAIL reset_store got %h exp 0", ex_store_data); else n_pass++;
    n_checks++;
    if ({ex_dest, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, load_use_stall} !== 11'b0)
      $display("FAIL reset_ctrl got dest=%0d v=%b mr=%b mw=%b rw=%b m2r=%b lus=%b exp all 0",
               ex_dest, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, load_use_stall);
    else n_pass++;
  endtask

  task automatic test_rtype();
    clear_inputs();
    id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100010;
    id_rs = 1; id_rt = 2; id_rd = 5; id_rs_data = 9; id_rt_data = 4;
    id_reg_dst = 1; id_reg_write = 1;
    tick();
    n_checks++; if (selector !== 4'b0110) $display("FAIL rtype_sel got %b exp 0110", selector); else n_pass++;
    n_checks++; if (operador1 !== 32'd9) $display("FAIL rtype_op1 got %0d exp 9", operador1); else n_pass++;
    n_checks++; if (operador2 !== 32'd4) $display("FAIL rtype_op2 got %0d exp 4", operador2); else n_pass++;
    n_checks++; if (ex_dest !== 5'd5) $display("FAIL rtype_dest got %0d exp 5", ex_dest); else n_pass++;
    n_checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1)
      $display("FAIL rtype_ctrl got v=%b rw=%b exp 1 1", ex_valid, ex_reg_write); else n_pass++;
  endtask

  task automatic test_selector_table();
    logic [1:0] ops   [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] fns   [8] = '{6'b100010, 6'b100000, 6'b000000, 6'b100100,
                              6'b100101, 6'b101010, 6'b100111, 6'b000011};
    logic [3:0] exps  [8] = '{4'b0010, 4'b0110, 4'b0001, 4'b0000,
                              4'b0001, 4'b0111, 4'b1100, 4'b1111};
    clear_inputs();
    id_valid = 1; id_rt = 3;
    for (int i = 0; i < 8; i++) begin
      id_alu_op = ops[i]; id_funct = fns[i];
      tick();
      n_checks++;
      if (selector !== exps[i])
        $display("FAIL sel_table[%0d] op=%b funct=%b got %b exp %b", i, ops[i], fns[i], selector, exps[i]);
      else n_pass++;
    end
    n_checks++; if (ex_dest !== 5'd3) $display("FAIL rt_dest got %0d exp 3", ex_dest); else n_pass++;
  endtask

  task automatic test_forwarding();
    clear_inputs();
    id_valid = 1; id_rs = 3; id_rt = 6; id_rs_data = 11; id_rt_data = 22;
    tick();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 7;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 5;
    #1;
    n_checks++; if (operador1 !== 32'd7) $display("FAIL fwd_exmem_prio got %0d exp 7", operador1); else n_pass++;
    exmem_reg_write = 0;
    #1;
    n_checks++; if (operador1 !== 32'd5) $display("FAIL fwd_memwb got %0d exp 5", operador1); else n_pass++;
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    #1;
    n_checks++; if (operador1 !== 32'd11) $display("FAIL fwd_r0 got %0d exp 11", operador1); else n_pass++;
    memwb_rd = 6;
    #1;
    n_checks++; if (operador2 !== 32'd5 || ex_store_data !== 32'd5)
      $display("FAIL fwd_b_memwb got op2=%0d st=%0d exp 5 5", operador2, ex_store_data); else n_pass++;
    n_checks++; if (operador1 !== 32'd11) $display("FAIL fwd_a_unaffected got %0d exp 11", operador1); else n_pass++;
  endtask

  task automatic test_load_use();
    clear_inputs();
    // lw $2, 4($1)
    id_valid = 1; id_rs = 1; id_rt = 2; id_imm = 4; id_alu_src = 1;
    id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    tick();
    // same-register rt with immediate operand is not a hazard
    id_mem_read = 0; id_mem_to_reg = 0; id_rs = 1; id_rt = 2; id_alu_src = 1;
    #1;
    n_checks++; if (load_use_stall !== 1'b0) $display("FAIL lus_imm got %b exp 0", load_use_stall); else n_pass++;
    // add $4, $2, $1
    id_rs = 2; id_rt = 1; id_rd = 4; id_reg_dst = 1; id_alu_src = 0;
    id_alu_op = 2'b10; id_funct = 6'b100000; id_rs_data = 100; id_rt_data = 30;
    #1;
    n_checks++; if (load_use_stall !== 1'b1) $display("FAIL lus_detect got %b exp 1", load_use_stall); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0)
      $display("FAIL lus_bubble got v=%b rw=%b exp 0 0", ex_valid, ex_reg_write); else n_pass++;
    n_checks++; if (load_use_stall !== 1'b0) $display("FAIL lus_release got %b exp 0", load_use_stall); else n_pass++;
    tick();
    memwb_reg_write = 1; memwb_rd = 2; memwb_result = 32'h55;
    #1;
    n_checks++; if (ex_valid !== 1'b1 || ex_dest !== 5'd4)
      $display("FAIL lus_add_cap got v=%b dest=%0d exp 1 4", ex_valid, ex_dest); else n_pass++;
    n_checks++; if (operador1 !== 32'h55 || operador2 !== 32'd30)
      $display("FAIL lus_add_fwd got op1=%h op2=%0d exp 55 30", operador1, operador2); else n_pass++;
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    id_valid = 1; id_alu_op = 2'b01; id_rs = 1; id_rt = 7; id_reg_write = 1;
    id_rs_data = 32'h111; id_rt_data = 32'h222;
    tick();
    stall = 1;
    id_alu_op = 2'b11; id_rt = 9; id_rs_data = 32'hAAA; id_rt_data = 32'hBBB; id_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (operador1 !== 32'h111 || operador2 !== 32'h222 || selector !== 4'b0110 ||
          ex_dest !== 5'd7 || ex_valid !== 1'b1)
        $display("FAIL stall_hold[%0d] got op1=%h op2=%h sel=%b dest=%0d v=%b exp 111 222 0110 7 1",
                 i, operador1, operador2, selector, ex_dest, ex_valid);
      else n_pass++;
    end
    flush = 1; id_valid = 1;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || selector !== 4'b0000)
      $display("FAIL flush_over_stall got v=%b rw=%b sel=%b exp 0 0 0000", ex_valid, ex_reg_write, selector);
    else n_pass++;
    stall = 0; flush = 0;
  endtask

  task automatic test_store();
    clear_inputs();
    id_valid = 1; id_mem_write = 1; id_alu_src = 1; id_imm = 16;
    id_rs = 4; id_rt = 8; id_rs_data = 32'h1000; id_rt_data = 32'h1;
    tick();
    exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'hDEAD;
    #1;
    n_checks++; if (operador2 !== 32'd16) $display("FAIL sw_op2 got %h exp 10", operador2); else n_pass++;
    n_checks++; if (ex_store_data !== 32'hDEAD) $display("FAIL sw_store got %h exp dead", ex_store_data); else n_pass++;
    n_checks++; if (selector !== 4'b0010) $display("FAIL sw_sel got %b exp 0010", selector); else n_pass++;
    n_checks++; if (ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0 || operador1 !== 32'h1000)
      $display("FAIL sw_ctrl got mw=%b rw=%b op1=%h exp 1 0 1000", ex_mem_write, ex_reg_write, operador1);
    else n_pass++;
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_rtype();
    test_selector_table();
    test_forwarding();
    test_load_use();
    test_stall_flush();
    test_store();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
